fact_sequencer: RTL and testbench
=================================

FACT_SEQUENCER -- requirements
Module: fact_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: datapath word width.
REQ-002 SHALL have parameter N_W, default 8: width of operand n_in.
REQ-003 SHALL have clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have start, input, 1: request to compute n_in!; sampled only in IDLE.
REQ-006 SHALL have n_in, input, N_W: operand, captured when start is accepted.
REQ-007 SHALL have is_zero, input, 1: datapath flag, high when ALU result == 0.
REQ-008 SHALL have result, input, DATA_W: datapath ALU output.
REQ-009 SHALL have write_en, wd_selec, read_imm, outputs, 1 each: regfile write enable; write-data select (1 = imm, 0 = ALU); ALU operand-B select (1 = imm).
REQ-010 SHALL have read_add1, read_add2, write_add, outputs, 2 each: regfile addresses.
REQ-011 SHALL have operation, output, 3: ALU opcode.
REQ-012 SHALL have imm, output, DATA_W: immediate to datapath.
REQ-013 SHALL have busy, output, 1: high in any state except IDLE.
REQ-014 SHALL have done, output, 1: registered one-cycle completion pulse.
REQ-015 SHALL have fact_out, output, DATA_W: registered final result.
REQ-016 SHALL have ovf, output, 1: high when the latched n exceeds 12.

Function
REQ-017 SHALL use the FSM states IDLE, LOAD_N, LOAD_ACC, CHECK, MUL, DEC, DONE, one state per cycle.
REQ-018 SHALL map registers as R0 = counter (2'b00) and R1 = accumulator (2'b01).
REQ-019 SHALL use opcodes OP_SUB = 3'b001, OP_MUL = 3'b010, OP_PASS = 3'b011 (A passed through).
REQ-020 SHALL go IDLE -> LOAD_N on start; LOAD_N drives write_en=1, write_add=R0, wd_selec=1, imm=n_in zero-extended.
REQ-021 SHALL go LOAD_N -> LOAD_ACC; LOAD_ACC drives write_en=1, write_add=R1, wd_selec=1, imm=1.
REQ-022 SHALL go LOAD_ACC -> CHECK; CHECK drives read_add1=R0, OP_PASS, write_en=0, then goes to DONE if is_zero else MUL.
REQ-023 SHALL have MUL drive read_add1=R0, read_add2=R1, read_imm=0, OP_MUL, wd_selec=0, write_en=1, write_add=R1, then go to DEC.
REQ-024 SHALL have DEC drive read_add1=R0, read_imm=1, imm=1, OP_SUB, wd_selec=0, write_en=1, write_add=R0, then go to CHECK.
REQ-025 SHALL have DONE drive read_add1=R1, OP_PASS; on its edge, fact_out <= result, done <= 1, state -> IDLE.
REQ-026 SHALL drive every control output not listed for a state to 0, never X.
REQ-027 SHALL assert done exactly 3n+4 cycles after the edge that accepts start (n=0: 4 cycles).
REQ-028 SHALL ignore start while busy and SHALL NOT let n_in changes while busy affect the run.
REQ-029 SHALL make arithmetic modulo 2^DATA_W; ovf is latched at start acceptance and held until the next accepted start.
REQ-030 SHALL accept a start asserted in the cycle done is high (state IDLE) and begin a new run.
REQ-031 SHALL hold fact_out until the next DONE.

Reset
REQ-032 SHALL, with rst_n low at any time including mid-run, force state=IDLE and busy, done, ovf, write_en, fact_out and all other outputs to 0 immediately.
REQ-033 SHALL, after reset, require a fresh start and SHALL NOT resume an interrupted run.

Structure
REQ-034 SHALL take from shared package fact_pkg: the state enum, OP_SUB/OP_MUL/OP_PASS, register indices R0/R1 and MAX_N=12.
REQ-035 SHALL implement the state-to-control decode as combinational sub-module fact_ctrl_decode; state register, done, fact_out and ovf registers remain in fact_sequencer.

Verification
REQ-036 SHALL verify, with the bench's 4x32 regfile + ALU model, that n=5 -> done 19 cycles after start accepted, fact_out=120, ovf=0.
REQ-037 SHALL verify that n=0 -> done after 4 cycles, fact_out=1, no MUL/DEC states visited.
REQ-038 SHALL verify that n=12 -> fact_out=479001600, ovf=0; and n=13 -> fact_out=1932053504, ovf=1.
REQ-039 SHALL verify that n=3 running with start re-pulsed and n_in=7 mid-run -> fact_out=6, single done pulse.
REQ-040 SHALL verify that rst_n low during MUL of n=6 -> outputs 0 at once, state IDLE; then start n=4 -> fact_out=24.
REQ-041 SHALL verify that back-to-back start in the done cycle with n=2 then n=3 -> fact_out 2 then 6, two done pulses.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared definitions for the factorial sequencer: FSM states, ALU opcodes,
// register-file indices and the largest operand whose factorial fits 32 bits.
// Latency: n/a (definitions only). Backpressure: n/a.
package fact_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_N   = 3'd1,
        LOAD_ACC = 3'd2,
        CHECK    = 3'd3,
        MUL      = 3'd4,
        DEC      = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;

    // R0 holds the down-counter, R1 the running product.
    localparam logic [1:0] R0 = 2'b00;
    localparam logic [1:0] R1 = 2'b01;

    localparam int MAX_N = 12;

endpackage

// File: rtl/fact_ctrl_decode.sv
// Purpose: combinational state-to-control decode for the factorial sequencer.
// Latency: zero cycles (pure combinational). Backpressure: none; follows state.
// Ports: state/n_val in; regfile addresses, write controls, ALU opcode and immediate out.
module fact_ctrl_decode
    import fact_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 8
) (
    input  state_t            state,
    input  logic [N_W-1:0]    n_val,
    output logic              write_en,
    output logic              wd_selec,
    output logic              read_imm,
    output logic [1:0]        read_add1,
    output logic [1:0]        read_add2,
    output logic [1:0]        write_add,
    output logic [2:0]        operation,
    output logic [DATA_W-1:0] imm
);

    always_comb begin
        // Everything idles at zero; each state only raises what it needs.
        write_en  = 1'b0;
        wd_selec  = 1'b0;
        read_imm  = 1'b0;
        read_add1 = 2'b00;
        read_add2 = 2'b00;
        write_add = 2'b00;
        operation = 3'b000;
        imm       = '0;

        case (state)
            LOAD_N: begin
                write_en  = 1'b1;
                write_add = R0;
                wd_selec  = 1'b1;
                imm       = DATA_W'(n_val);
            end
            LOAD_ACC: begin
                write_en  = 1'b1;
                write_add = R1;
                wd_selec  = 1'b1;
                imm       = DATA_W'(1);
            end
            CHECK: begin
                // Pass the counter through the ALU so is_zero reflects it.
                read_add1 = R0;
                operation = OP_PASS;
            end
            MUL: begin
                read_add1 = R0;
                read_add2 = R1;
                operation = OP_MUL;
                write_en  = 1'b1;
                write_add = R1;
            end
            DEC: begin
                read_add1 = R0;
                read_imm  = 1'b1;
                imm       = DATA_W'(1);
                operation = OP_SUB;
                write_en  = 1'b1;
                write_add = R0;
            end
            DONE: begin
                read_add1 = R1;
                operation = OP_PASS;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fact_sequencer.sv
// Purpose: FSM sequencing an external regfile+ALU datapath to compute n_in! (mod 2^DATA_W).
// Latency: done pulses 3n+4 cycles after the edge that accepts start.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped.
// Ports: clk/rst_n; start/n_in request; is_zero/result from datapath;
//        datapath controls out; busy/done/fact_out/ovf status.
module fact_sequencer
    import fact_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_W-1:0]    n_in,
    input  logic              is_zero,
    input  logic [DATA_W-1:0] result,
    output logic              write_en,
    output logic              wd_selec,
    output logic              read_imm,
    output logic [1:0]        read_add1,
    output logic [1:0]        read_add2,
    output logic [1:0]        write_add,
    output logic [2:0]        operation,
    output logic [DATA_W-1:0] imm,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] fact_out,
    output logic              ovf
);

    localparam logic [N_W-1:0] MAX_N_W = N_W'(MAX_N);

    state_t         state;
    state_t         state_next;
    // Operand snapshot so n_in may change freely once a run is under way.
    logic [N_W-1:0] n_reg;
    logic           accept;

    assign accept = (state == IDLE) && start;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = LOAD_N;
            LOAD_N:   state_next = LOAD_ACC;
            LOAD_ACC: state_next = CHECK;
            CHECK:    state_next = is_zero ? DONE : MUL;
            MUL:      state_next = DEC;
            DEC:      state_next = CHECK;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg    <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
            fact_out <= '0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                fact_out <= result;
            end
            if (accept) begin
                n_reg <= n_in;
                ovf   <= (n_in > MAX_N_W);
            end
        end
    end

    fact_ctrl_decode #(
        .DATA_W (DATA_W),
        .N_W    (N_W)
    ) u_decode (
        .state     (state),
        .n_val     (n_reg),
        .write_en  (write_en),
        .wd_selec  (wd_selec),
        .read_imm  (read_imm),
        .read_add1 (read_add1),
        .read_add2 (read_add2),
        .write_add (write_add),
        .operation (operation),
        .imm       (imm)
    );

endmodule

// File: tb/tb_fact_sequencer.sv
// Bench for fact_sequencer: regfile+ALU datapath model around the DUT, a
// scoreboard queue of expected completions and a done-driven monitor.
// Stimulus: directed corner runs followed by randomized operands and re-pulses.
module tb_fact_sequencer;

    localparam int DATA_W = 32;
    localparam int N_W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [N_W-1:0]    n_in;
    logic              is_zero;
    logic [DATA_W-1:0] result;
    logic              write_en, wd_selec, read_imm;
    logic [1:0]        read_add1, read_add2, write_add;
    logic [2:0]        operation;
    logic [DATA_W-1:0] imm;
    logic              busy, done, ovf;
    logic [DATA_W-1:0] fact_out;

    always #5 clk = ~clk;

    fact_sequencer #(.DATA_W(DATA_W), .N_W(N_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_in      (n_in),
        .is_zero   (is_zero),
        .result    (result),
        .write_en  (write_en),
        .wd_selec  (wd_selec),
        .read_imm  (read_imm),
        .read_add1 (read_add1),
        .read_add2 (read_add2),
        .write_add (write_add),
        .operation (operation),
        .imm       (imm),
        .busy      (busy),
        .done      (done),
        .fact_out  (fact_out),
        .ovf       (ovf)
    );

    // ---------------- datapath model: 4x32 regfile + ALU ----------------
    logic [DATA_W-1:0] rf [4];
    logic [DATA_W-1:0] alu_a, alu_b;

    initial for (int i = 0; i < 4; i++) rf[i] = '0;

    always_comb begin
        alu_a = rf[read_add1];
        alu_b = read_imm ? imm : rf[read_add2];
        case (operation)
            3'b001:  result = alu_a - alu_b;
            3'b010:  result = alu_a * alu_b;
            3'b011:  result = alu_a;
            default: result = '0;
        endcase
        is_zero = (result == '0);
    end

    always @(posedge clk) begin
        if (write_en) rf[write_add] <= wd_selec ? imm : result;
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [DATA_W-1:0] f;
        logic              o;
        int                cyc;
        int                n;
    } exp_t;

    exp_t exp_q [$];
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    bit   mul_seen = 0;

    always @(posedge clk) cyc++;

    function automatic logic [DATA_W-1:0] fact_ref(input int n);
        logic [DATA_W-1:0] f = 1;
        for (int i = 2; i <= n; i++) f = f * DATA_W'(i);
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if ($isunknown({write_en, wd_selec, read_imm, read_add1, read_add2,
                            write_add, operation, imm, busy, done, ovf})) begin
                check("outputs_known", 64'd1, 64'd0);
            end
            if (operation == 3'b010) mul_seen = 1;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("fact_out_n%0d", e.n), 64'(fact_out), 64'(e.f));
                    check($sformatf("ovf_n%0d", e.n), 64'(ovf), 64'(e.o));
                    check($sformatf("latency_n%0d", e.n), 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Called at a negedge. Expectation is queued only if the DUT is idle,
    // i.e. the next rising edge will accept it.
    task automatic issue(input int n);
        exp_t e;
        start = 1'b1;
        n_in  = N_W'(n);
        if (!busy) begin
            e.f   = fact_ref(n);
            e.o   = (n > 12);
            e.cyc = cyc + 1 + 3 * n + 4;
            e.n   = n;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        n_in  = N_W'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        if (k == 3000) begin
            check("wait_idle_timeout", 64'd1, 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 3000) check("wait_done_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int d0;
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        n_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_fact_out", 64'(fact_out), 64'd0);
        check("rst_ctrl", 64'({write_en, wd_selec, read_imm, read_add1, read_add2,
                               write_add, operation, ovf}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // n=5
        issue(5);
        wait_idle();
        check("n5_const", 64'(fact_out), 64'd120);

        // n=0: no multiply ever issued
        mul_seen = 0;
        issue(0);
        wait_idle();
        check("n0_const", 64'(fact_out), 64'd1);
        check("n0_no_mul", 64'(mul_seen), 64'd0);

        // 12 and 13 (wraps, flags overflow)
        issue(12);
        wait_idle();
        check("n12_const", 64'(fact_out), 64'd479001600);
        issue(13);
        wait_idle();
        check("n13_const", 64'(fact_out), 64'd1932053504);
        check("n13_ovf", 64'(ovf), 64'd1);

        // n=3 with re-pulses of start and n_in=7 while busy
        d0 = done_cnt;
        issue(3);
        repeat (2) @(negedge clk);
        issue(7);
        @(negedge clk);
        issue(7);
        wait_idle();
        check("repulse_fact", 64'(fact_out), 64'd6);
        check("repulse_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Reset during MUL of n=6
        issue(6);
        for (k = 0; k < 100; k++) begin
            if (operation == 3'b010) break;
            @(negedge clk);
        end
        if (k == 100) check("reach_mul_timeout", 64'd1, 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_fact_out", 64'(fact_out), 64'd0);
        check("midrst_ctrl", 64'({write_en, wd_selec, read_imm, read_add1, read_add2,
                                  write_add, operation, imm, done, ovf}), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_resume_busy", 64'(busy), 64'd0);
        issue(4);
        wait_idle();
        check("after_rst_fact", 64'(fact_out), 64'd24);

        // Back-to-back: start accepted in the done cycle
        d0 = done_cnt;
        issue(2);
        wait_done();
        check("b2b_first", 64'(fact_out), 64'd2);
        issue(3);
        wait_idle();
        check("b2b_second", 64'(fact_out), 64'd6);
        check("b2b_done_cnt", 64'(done_cnt - d0), 64'd2);

        // Randomized runs with occasional re-pulses while busy
        for (int t = 0; t < 40; t++) begin
            int n;
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40))
                                            : int'($urandom_range(0, 14));
            issue(n);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                issue(int'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 2) == 0) begin
                wait_done();
            end else begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        wait_idle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
